// File: rtl/quick_spi_pkg.sv
// Shared state encoding, wire-order constants and the wire-index to data-bit
// mapping rule for the quick SPI master.
package quick_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_READ,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam int BYTES_LITTLE_ENDIAN = 0;
  localparam int BYTES_BIG_ENDIAN    = 1;
  localparam int BITS_LSB_FIRST      = 0;
  localparam int BITS_MSB_FIRST      = 1;

  // Data bit index carried by wire position wire_idx (0 = first on the wire).
  function automatic int wire_to_data_index(int wire_idx, int width,
                                            int bytes_order, int bits_order);
    int byte_sel;
    int bit_sel;
    byte_sel = (bytes_order == BYTES_BIG_ENDIAN) ? (width / 8 - 1 - wire_idx / 8)
                                                 : (wire_idx / 8);
    bit_sel  = (bits_order == BITS_MSB_FIRST) ? (7 - wire_idx % 8) : (wire_idx % 8);
    return byte_sel * 8 + bit_sel;
  endfunction

endpackage

// File: rtl/quick_spi_bit_mapper.sv
// Combinational reorder between a data word and its wire sequence
// (bit i of the wire word is the i-th bit on the wire).
module quick_spi_bit_mapper
  import quick_spi_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int BYTES_ORDER = BYTES_BIG_ENDIAN,
  parameter int BITS_ORDER  = BITS_MSB_FIRST,
  parameter bit TO_WIRE     = 1'b1
) (
  input  logic [WIDTH-1:0] in_word,
  output logic [WIDTH-1:0] out_word
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int D = wire_to_data_index(i, WIDTH, BYTES_ORDER, BITS_ORDER);
    if (TO_WIRE) begin : g_fwd
      assign out_word[i] = in_word[D];
    end else begin : g_inv
      assign out_word[D] = in_word[i];
    end
  end

endmodule

// File: rtl/quick_spi_master.sv
// Mode-0 SPI master: SCLK at clk/2, write phase then optional read phase,
// configurable byte and bit order on the wire.
module quick_spi_master
  import quick_spi_pkg::*;
#(
  parameter int BYTES_ORDER         = BYTES_BIG_ENDIAN,
  parameter int BITS_ORDER          = BITS_MSB_FIRST,
  parameter int OUTGOING_DATA_WIDTH = 16,
  parameter int INCOMING_DATA_WIDTH = 8,
  parameter int NUMBER_OF_SLAVES    = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           start_transaction,
  input  logic [NUMBER_OF_SLAVES-1:0]    slave,
  input  logic                           operation,
  input  logic [OUTGOING_DATA_WIDTH-1:0] outgoing_data,
  output logic                           end_of_transaction,
  output logic [INCOMING_DATA_WIDTH-1:0] incoming_data,
  output logic                           mosi,
  input  logic                           miso,
  output logic                           sclk,
  output logic [NUMBER_OF_SLAVES-1:0]    ss_n
);

  localparam int MAXW  = (OUTGOING_DATA_WIDTH > INCOMING_DATA_WIDTH) ?
                         OUTGOING_DATA_WIDTH : INCOMING_DATA_WIDTH;
  localparam int CNT_W = $clog2(2 * MAXW);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(2 * OUTGOING_DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(2 * INCOMING_DATA_WIDTH - 1);

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic                           op_q;
  logic [OUTGOING_DATA_WIDTH-1:0] tx_wire;
  logic [OUTGOING_DATA_WIDTH-1:0] tx_sh;
  logic [INCOMING_DATA_WIDTH-1:0] rx_sh;
  logic [INCOMING_DATA_WIDTH-1:0] rx_data;

  // The input word is reordered before latching so the shift register can
  // simply emit bit 0 first; the latched value is identical either way.
  quick_spi_bit_mapper #(
    .WIDTH      (OUTGOING_DATA_WIDTH),
    .BYTES_ORDER(BYTES_ORDER),
    .BITS_ORDER (BITS_ORDER),
    .TO_WIRE    (1'b1)
  ) u_tx_map (
    .in_word (outgoing_data),
    .out_word(tx_wire)
  );

  quick_spi_bit_mapper #(
    .WIDTH      (INCOMING_DATA_WIDTH),
    .BYTES_ORDER(BYTES_ORDER),
    .BITS_ORDER (BITS_ORDER),
    .TO_WIRE    (1'b0)
  ) u_rx_map (
    .in_word (rx_sh),
    .out_word(rx_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      cnt                <= '0;
      op_q               <= 1'b0;
      tx_sh              <= '0;
      rx_sh              <= '0;
      ss_n               <= '1;
      sclk               <= 1'b0;
      mosi               <= 1'b0;
      end_of_transaction <= 1'b0;
      incoming_data      <= '0;
    end else if (!enable) begin
      state              <= ST_IDLE;
      ss_n               <= '1;
      sclk               <= 1'b0;
      mosi               <= 1'b0;
      end_of_transaction <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          end_of_transaction <= 1'b0;
          if (start_transaction) begin
            op_q  <= operation;
            tx_sh <= tx_wire;
            mosi  <= tx_wire[0];
            ss_n  <= ~slave;
            sclk  <= 1'b0;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt   <= '0;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (cnt == WR_LAST) begin
            cnt   <= '0;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
            state <= op_q ? ST_READ : ST_HOLD;
          end else begin
            cnt  <= cnt + 1'b1;
            sclk <= ~cnt[0];
            // Leaving an sclk-high cycle: next bit goes out with the falling edge.
            if (cnt[0]) begin
              tx_sh <= tx_sh >> 1;
              mosi  <= tx_sh[1];
            end
          end
        end
        ST_READ: begin
          if (cnt[0]) rx_sh <= {miso, rx_sh[INCOMING_DATA_WIDTH-1:1]};
          if (cnt == RD_LAST) begin
            sclk  <= 1'b0;
            state <= ST_HOLD;
          end else begin
            cnt  <= cnt + 1'b1;
            sclk <= ~cnt[0];
          end
        end
        ST_HOLD: begin
          ss_n               <= '1;
          end_of_transaction <= 1'b1;
          if (op_q) incoming_data <= rx_data;
          state <= ST_DONE;
        end
        ST_DONE: begin
          end_of_transaction <= 1'b0;
          state              <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_spi_master.sv
// Bench for quick_spi_master: two instances (BE/LSB-first and LE/MSB-first)
// share stimulus and are checked cycle by cycle against a wire-order model.
module tb_quick_spi_master;

  localparam int OW = 16;
  localparam int IW = 8;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic reset_n, enable, start_transaction, operation, miso;
  logic [NS-1:0] slave;
  logic [OW-1:0] outgoing_data;
  logic eot_a, eot_b, mosi_a, mosi_b, sclk_a, sclk_b;
  logic [NS-1:0] ss_a, ss_b;
  logic [IW-1:0] in_a, in_b;
  logic [IW-1:0] last_a, last_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  quick_spi_master #(
    .BYTES_ORDER(1), .BITS_ORDER(0),
    .OUTGOING_DATA_WIDTH(OW), .INCOMING_DATA_WIDTH(IW), .NUMBER_OF_SLAVES(NS)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .start_transaction(start_transaction), .slave(slave), .operation(operation),
    .outgoing_data(outgoing_data), .end_of_transaction(eot_a),
    .incoming_data(in_a), .mosi(mosi_a), .miso(miso), .sclk(sclk_a), .ss_n(ss_a)
  );

  quick_spi_master #(
    .BYTES_ORDER(0), .BITS_ORDER(1),
    .OUTGOING_DATA_WIDTH(OW), .INCOMING_DATA_WIDTH(IW), .NUMBER_OF_SLAVES(NS)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .start_transaction(start_transaction), .slave(slave), .operation(operation),
    .outgoing_data(outgoing_data), .end_of_transaction(eot_b),
    .incoming_data(in_b), .mosi(mosi_b), .miso(miso), .sclk(sclk_b), .ss_n(ss_b)
  );

  typedef struct {
    logic          op;
    logic [NS-1:0] slv;
    logic [OW-1:0] data;
    logic [IW-1:0] rx;
    logic [OW-1:0] seq_a;
    logic [OW-1:0] seq_b;
    logic [IW-1:0] in_a;
    logic [IW-1:0] in_b;
  } vec_t;

  vec_t tbl[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wire sequence: bit i is the i-th bit sent.
  function automatic logic [OW-1:0] wire_seq(input logic [OW-1:0] d, input bit be, input bit msb);
    logic [7:0] bq[$];
    logic [OW-1:0] s;
    int pos;
    s = '0;
    pos = 0;
    for (int n = 0; n < OW / 8; n++) bq.push_back(d[n*8 +: 8]);
    if (be) bq.reverse();
    foreach (bq[j]) begin
      for (int t = 0; t < 8; t++) begin
        s[pos] = msb ? bq[j][7-t] : bq[j][t];
        pos++;
      end
    end
    return s;
  endfunction

  function automatic logic [IW-1:0] rx_word(input logic [IW-1:0] seq, input bit be, input bit msb);
    logic [7:0] bq[$];
    logic [7:0] b;
    logic [IW-1:0] d;
    for (int n = 0; n < IW / 8; n++) begin
      for (int t = 0; t < 8; t++) b[msb ? 7 - t : t] = seq[n*8 + t];
      bq.push_back(b);
    end
    if (be) bq.reverse();
    d = '0;
    for (int n = 0; n < IW / 8; n++) d[n*8 +: 8] = bq[n];
    return d;
  endfunction

  task automatic txn(input logic op, input logic [NS-1:0] slv, input logic [OW-1:0] data,
                     input logic [IW-1:0] rx, input logic [OW-1:0] sa, input logic [OW-1:0] sb,
                     input logic [IW-1:0] ia, input logic [IW-1:0] ib, input bit keep_start);
    int last, rises_a, rises_b, rd0;
    logic prev_a, prev_b, esclk;
    logic [NS-1:0] ess;
    bit wr, rd;
    last = op ? 2*OW + 2*IW + 3 : 2*OW + 3;
    rd0 = 2*OW + 2;
    rises_a = 0; rises_b = 0; prev_a = 1'b0; prev_b = 1'b0;
    @(negedge clk);
    chk("idle_a", {ss_a, sclk_a, mosi_a, eot_a}, {{NS{1'b1}}, 3'b000});
    chk("idle_b", {ss_b, sclk_b, mosi_b, eot_b}, {{NS{1'b1}}, 3'b000});
    operation = op; slave = slv; outgoing_data = data; start_transaction = 1'b1; miso = 1'b0;
    @(posedge clk);
    #1;
    start_transaction = keep_start;
    operation = keep_start ? ~op : 1'($urandom);
    slave = NS'($urandom);
    outgoing_data = OW'($urandom);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      wr = (c >= 2) && (c <= 2*OW + 1);
      rd = op && (c >= rd0) && (c <= 2*OW + 2*IW + 1);
      esclk = wr ? 1'((c - 2) % 2) : rd ? 1'((c - rd0) % 2) : 1'b0;
      ess = (c == last) ? {NS{1'b1}} : ~slv;
      chk($sformatf("ctl_a c%0d", c), {ss_a, sclk_a, eot_a}, {ess, esclk, c == last});
      chk($sformatf("ctl_b c%0d", c), {ss_b, sclk_b, eot_b}, {ess, esclk, c == last});
      if (c == 1) begin
        chk("mosi_a setup", mosi_a, sa[0]);
        chk("mosi_b setup", mosi_b, sb[0]);
      end else if (wr) begin
        chk($sformatf("mosi_a c%0d", c), mosi_a, sa[(c - 2) / 2]);
        chk($sformatf("mosi_b c%0d", c), mosi_b, sb[(c - 2) / 2]);
      end else if (rd) begin
        chk($sformatf("mosi_a rd c%0d", c), mosi_a, 1'b0);
        chk($sformatf("mosi_b rd c%0d", c), mosi_b, 1'b0);
      end
      if (sclk_a && !prev_a) rises_a++;
      if (sclk_b && !prev_b) rises_b++;
      prev_a = sclk_a; prev_b = sclk_b;
      if (rd && ((c - rd0) % 2 == 0)) miso = rx[(c - rd0) / 2];
    end
    if (op) begin
      last_a = ia; last_b = ib;
    end
    chk("incoming_a", in_a, last_a);
    chk("incoming_b", in_b, last_b);
    chk("sclk_rises_a", rises_a, op ? OW + IW : OW);
    chk("sclk_rises_b", rises_b, op ? OW + IW : OW);
  endtask

  task automatic model_txn(input logic op, input logic [NS-1:0] slv, input logic [OW-1:0] data,
                           input logic [IW-1:0] rx, input bit keep_start);
    txn(op, slv, data, rx, wire_seq(data, 1, 0), wire_seq(data, 0, 1),
        rx_word(rx, 1, 0), rx_word(rx, 0, 1), keep_start);
  endtask

  task automatic launch(input logic op, input logic [NS-1:0] slv, input logic [OW-1:0] data);
    @(negedge clk);
    operation = op; slave = slv; outgoing_data = data; start_transaction = 1'b1;
    @(posedge clk);
    #1;
    start_transaction = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    reset_n = 1'b0; enable = 1'b1; start_transaction = 1'b0; operation = 1'b0;
    slave = '0; outgoing_data = '0; miso = 1'b0;
    last_a = '0; last_b = '0;

    tbl[0] = '{op: 1'b0, slv: 2'b01, data: 16'hCC81, rx: 8'h00,
               seq_a: 16'h81CC, seq_b: 16'h3381, in_a: 8'h00, in_b: 8'h00};
    tbl[1] = '{op: 1'b1, slv: 2'b01, data: 16'hCC81, rx: 8'h95,
               seq_a: 16'h81CC, seq_b: 16'h3381, in_a: 8'h95, in_b: 8'hA9};
    tbl[2] = '{op: 1'b0, slv: 2'b10, data: 16'h0001, rx: 8'h00,
               seq_a: 16'h0100, seq_b: 16'h0080, in_a: 8'h00, in_b: 8'h00};

    repeat (3) @(negedge clk);
    chk("reset_a", {ss_a, sclk_a, mosi_a, eot_a, in_a}, {2'b11, 3'b000, 8'h00});
    chk("reset_b", {ss_b, sclk_b, mosi_b, eot_b, in_b}, {2'b11, 3'b000, 8'h00});
    reset_n = 1'b1;

    // Enable low keeps the block idle even with a pending request.
    enable = 1'b0; start_transaction = 1'b1; slave = 2'b01;
    repeat (4) begin
      @(negedge clk);
      chk("en_low_a", {ss_a, sclk_a, eot_a}, {2'b11, 2'b00});
      chk("en_low_b", {ss_b, sclk_b, eot_b}, {2'b11, 2'b00});
    end
    start_transaction = 1'b0; enable = 1'b1;

    foreach (tbl[i])
      txn(tbl[i].op, tbl[i].slv, tbl[i].data, tbl[i].rx, tbl[i].seq_a, tbl[i].seq_b,
          tbl[i].in_a, tbl[i].in_b, 1'b0);

    // Back-to-back with start held high, operation alternating.
    model_txn(1'b0, 2'b10, 16'h5A3C, 8'h00, 1'b1);
    model_txn(1'b1, 2'b10, 16'h1234, 8'h6E, 1'b1);
    model_txn(1'b0, 2'b01, 16'hFFFE, 8'h00, 1'b0);

    // Enable dropped mid-WRITE aborts with no pulse.
    launch(1'b0, 2'b01, 16'hA5A5);
    repeat (9) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_a", {ss_a, sclk_a, eot_a}, {2'b11, 2'b00});
    chk("abort_b", {ss_b, sclk_b, eot_b}, {2'b11, 2'b00});
    enable = 1'b1;
    pulses = 0;
    repeat (45) begin
      @(negedge clk);
      if (eot_a || eot_b) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_keep_a", in_a, last_a);
    chk("abort_keep_b", in_b, last_b);

    // Reset asserted mid-READ clears outputs asynchronously.
    launch(1'b1, 2'b10, 16'h0F0F);
    miso = 1'b1;
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_a", {ss_a, sclk_a, mosi_a, eot_a, in_a}, {2'b11, 3'b000, 8'h00});
    chk("midrst_b", {ss_b, sclk_b, mosi_b, eot_b, in_b}, {2'b11, 3'b000, 8'h00});
    last_a = '0; last_b = '0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++)
      model_txn(1'($urandom_range(0, 1)), NS'(1 << $urandom_range(0, NS - 1)),
                OW'($urandom), IW'($urandom), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quick_spi_master.md
# quick_spi_master

SPI master (mode 0: CPOL=0, CPHA=0) that serialises a parallel outgoing word to one selected slave and, for read operations, then captures an incoming word from `miso`. Byte order and bit-within-byte order on the wire are set by parameters. It sits between a register/command front-end and external SPI devices. SCLK is derived from the system clock at clk/2.

## Interface
- `BYTES_ORDER`, default 1: 1 = big endian (most significant byte on the wire first); 0 = little endian (byte 0 first).
- `BITS_ORDER`, default 1: 1 = MSB of each byte first; 0 = LSB of each byte first.
- `OUTGOING_DATA_WIDTH`, default 16: bits sent per transaction; must be a multiple of 8.
- `INCOMING_DATA_WIDTH`, default 8: bits received per read; must be a multiple of 8.
- `NUMBER_OF_SLAVES`, default 2: width of `slave` and `ss_n`.
- `clk` in 1: system clock. The block has one clock.
- `reset_n` in 1: reset. Asynchronous, active-low.
- `enable` in 1: block enable. Low forces and holds the idle state.
- `start_transaction` in 1: level request. Sampled only in IDLE.
- `slave` in NUMBER_OF_SLAVES: one-hot slave mask. Latched at start.
- `operation` in 1: 0 = write, 1 = read. Latched at start.
- `outgoing_data` in OUTGOING_DATA_WIDTH: word to send. Latched at start.
- `end_of_transaction` out 1: one-cycle completion pulse.
- `incoming_data` out INCOMING_DATA_WIDTH: last word read. Held until the next read completes.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.
- `sclk` out 1: SPI clock. Idles low.
- `ss_n` out NUMBER_OF_SLAVES: active-low slave selects.

## Operation
- States: IDLE, SETUP, WRITE, READ, HOLD, DONE.
- IDLE → SETUP: when `enable && start_transaction`. Latch `operation`, `slave` and `outgoing_data`.
- SETUP (1 cycle):
  - `ss_n = ~slave_latched`; `sclk` = 0.
  - `mosi` drives bit 0 of the transmit sequence.
- WRITE (2·OUTGOING_DATA_WIDTH cycles):
  - Bit k occupies cycles 2k (`sclk`=0) and 2k+1 (`sclk`=1).
  - `mosi` changes only in the first cycle of each bit, i.e. with the falling or idle-low SCLK.
- After WRITE: read operations go to READ; writes go to HOLD.
- READ (2·INCOMING_DATA_WIDTH cycles):
  - Same SCLK pattern as WRITE; `mosi` = 0.
  - `miso` is sampled at the clk edge that ends each `sclk`=1 cycle (just before SCLK falls).
- HOLD (1 cycle): `ss_n` still asserted, `sclk` = 0.
- DONE (1 cycle):
  - `ss_n` all ones; `end_of_transaction` = 1.
  - On a read, `incoming_data` updates in this cycle.
  - Next state is IDLE.
- Transmit sequence: bytes are taken in BYTES_ORDER order; bits within each byte are taken in BITS_ORDER order.
- Receive mapping uses the same rule: the first received bit goes to the position that would have been sent first.
- If `enable` drops in any non-IDLE state, the transaction aborts to IDLE on the next edge:
  - `ss_n` goes to all ones and `sclk` to 0.
  - No `end_of_transaction` pulse; `incoming_data` is unchanged.
- `start_transaction` still high in IDLE after DONE starts a new transaction. Changing inputs mid-transaction has no effect.

## Timing
- Reset values: `ss_n` all ones, `sclk` 0, `mosi` 0, `end_of_transaction` 0, `incoming_data` 0. State = IDLE.
- Reset asserted mid-transaction returns all outputs to these values immediately.
- Write latency: start sampled at edge 0 → `end_of_transaction` high for 2·OUT + 3 cycles after edge 0 (SETUP + WRITE + HOLD), i.e. 35 cycles for default widths.
- Read latency: 2·OUT + 2·IN + 3 cycles (51 for defaults).
- Minimum gap between transactions: one IDLE cycle after DONE.
- `sclk` frequency = clk/2, 50% duty cycle. No SCLK edges outside WRITE and READ.

## Structure
- Package `quick_spi_pkg`:
  - State enum.
  - Constants `BYTES_LITTLE_ENDIAN`=0, `BYTES_BIG_ENDIAN`=1, `BITS_LSB_FIRST`=0, `BITS_MSB_FIRST`=1.
- Sub-module `quick_spi_bit_mapper`: combinational, parameterised width/BYTES_ORDER/BITS_ORDER. Maps wire-sequence index ↔ data bit index.
  - One instance reorders the latched outgoing word into a linear shift word.
  - One instance un-reorders the received shift register.
- Top level holds the FSM, bit counter, SCLK toggle and shift registers.

## Test plan
- BE, LSB-first write, `outgoing_data`=0xCC81, `slave`=2'b01:
  - `ss_n`=2'b10 during the transaction.
  - `mosi` sequence 0,0,1,1,0,0,1,1, then 1,0,0,0,0,0,0,1.
  - 16 SCLK rising edges; `end_of_transaction` at cycle 35.
- Same settings, read with `miso` driving 1,0,1,0,1,0,0,1 in the read phase:
  - `incoming_data`=0x95 at DONE.
  - 24 SCLK rising edges; pulse at cycle 51.
- LE, MSB-first write of 0xCC81 → `mosi` 1,0,0,0,0,0,0,1, then 1,1,0,0,1,1,0,0.
- `start_transaction` held high, `operation` toggled each DONE:
  - Write and read alternate, separated by one IDLE cycle.
  - Exactly one `end_of_transaction` pulse each.
- Drop `enable` during WRITE → `ss_n` all ones and `sclk`=0 next cycle; no pulse. Same for `reset_n` low mid-read → all reset values asynchronously.
